// File: rtl/axis_arb_rr.sv
// Round-robin arbiter sharing one AXI-stream sink between NUM_PORTS requesters.
// Each grant lasts up to MAX_BURST beats; the datapath is an unregistered mux.
module axis_arb_rr #(
   parameter int unsigned NUM_PORTS  = 4,
   parameter int unsigned DATA_WIDTH = 72,
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [ID_WIDTH-1:0]             m_axis_tid,
   output logic                            grant_active
);

   localparam int unsigned CntW = $clog2(MAX_BURST + 1);

   localparam logic StIdle  = 1'b0;
   localparam logic StGrant = 1'b1;

   localparam logic [ID_WIDTH-1:0] LastPort = ID_WIDTH'(NUM_PORTS - 1);
   localparam logic [CntW-1:0]     CntLast  = CntW'(MAX_BURST - 1);

   logic                state_q, state_d;
   logic [ID_WIDTH-1:0] grant_q, grant_d;
   logic [ID_WIDTH-1:0] last_q, last_d;
   logic [CntW-1:0]     cnt_q, cnt_d;

   logic                pick_valid;
   logic [ID_WIDTH-1:0] pick_idx;

   // Smallest rotation offset wins, so the port just after last_q has top priority.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
         int unsigned idx;
         idx = (int'(last_q) + k) % NUM_PORTS;
         if (s_axis_tvalid[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = ID_WIDTH'(idx);
         end
      end
   end

   // Data is zeroed when the granted port is not valid so X never leaks downstream.
   always_comb begin
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tid    = '0;
      if (state_q == StGrant) begin
         m_axis_tid = grant_q;
         for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == ID_WIDTH'(p)) begin
               m_axis_tvalid    = s_axis_tvalid[p];
               s_axis_tready[p] = m_axis_tready;
               if (s_axis_tvalid[p]) begin
                  m_axis_tdata = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end
      end
   end

   assign grant_active = (state_q == StGrant);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               state_d = StGrant;
               grant_d = pick_idx;
               cnt_d   = '0;
            end
         end
         StGrant: begin
            if (!m_axis_tvalid) begin
               state_d = StIdle;
               last_d  = grant_q;
            end else if (m_axis_tready) begin
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  state_d = StIdle;
                  last_d  = grant_q;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         last_q  <= LastPort;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_axis_arb_rr.sv
// Bench for axis_arb_rr: three instances (MAX_BURST 16, 4, 1) driven by AXI-compliant
// sources and compared every cycle against a port-ownership model.
module tb_axis_arb_rr;

   localparam int N    = 4;
   localparam int DW   = 16;
   localparam int IW   = 2;
   localparam int NI   = 3;
   localparam int LOGN = 128;
   localparam int MB_OF [NI] = '{16, 4, 1};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic [N-1:0]    sv  [NI];
   logic [N-1:0]    sr  [NI];
   logic [N*DW-1:0] sd  [NI];
   logic            mv  [NI];
   logic            mr  [NI];
   logic [DW-1:0]   md  [NI];
   logic [IW-1:0]   mid [NI];
   logic            ga  [NI];

   int compared   = 0;
   int mismatched = 0;

   // Model: owner = port holding the sink (-1 when none), beats taken, last owner.
   int owner [NI];
   int cnt   [NI];
   int last  [NI];

   bit            pend  [NI][N];
   logic [DW-1:0] pdata [NI][N];
   logic [DW-1:0] nextd [NI][N];
   int            left  [NI][N];
   bit            acc   [NI][N];
   int            prob;
   int            rdy_pct;

   int lg_n   [NI];
   int lg_tid [NI][LOGN];
   int lg_dat [NI][LOGN];
   int lg_cyc [NI][LOGN];
   int cyc = 0;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      axis_arb_rr #(
         .NUM_PORTS (N),
         .DATA_WIDTH(DW),
         .MAX_BURST (MB_OF[gi])
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .s_axis_tvalid(sv[gi]),
         .s_axis_tready(sr[gi]),
         .s_axis_tdata (sd[gi]),
         .m_axis_tvalid(mv[gi]),
         .m_axis_tready(mr[gi]),
         .m_axis_tdata (md[gi]),
         .m_axis_tid   (mid[gi]),
         .grant_active (ga[gi])
      );
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit busy();
      bit b = 1'b0;
      for (int i = 0; i < NI; i++) begin
         if (owner[i] >= 0) b = 1'b1;
         for (int p = 0; p < N; p++) if (pend[i][p] || left[i][p] > 0) b = 1'b1;
      end
      return b;
   endfunction

   task automatic refill();
      for (int i = 0; i < NI; i++) begin
         for (int p = 0; p < N; p++) begin
            if (acc[i][p]) begin
               pend[i][p] = 1'b0;
               acc[i][p]  = 1'b0;
            end
            if (!pend[i][p] && left[i][p] > 0 && int'($urandom_range(99, 0)) < prob) begin
               pend[i][p]  = 1'b1;
               pdata[i][p] = nextd[i][p];
               nextd[i][p] = nextd[i][p] + 16'd1;
               left[i][p]--;
            end
            sv[i][p]           = pend[i][p];
            sd[i][p*DW +: DW]  = pdata[i][p];
         end
         mr[i] = int'($urandom_range(99, 0)) < rdy_pct;
      end
   endtask

   // Check at the falling edge, advance the model, then drive new inputs after the rising edge.
   task automatic step();
      logic [N-1:0]  e_rdy;
      logic          e_val;
      logic [DW-1:0] e_dat;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         if (!rst_n) begin
            owner[i] = -1;
            cnt[i]   = 0;
            last[i]  = N - 1;
         end
         e_rdy = '0;
         e_val = 1'b0;
         e_dat = '0;
         if (owner[i] >= 0) begin
            e_val           = sv[i][owner[i]];
            e_rdy[owner[i]] = mr[i];
            e_dat           = sd[i][owner[i]*DW +: DW];
         end
         check($sformatf("u%0d m_tvalid", i), 64'(mv[i]), 64'(e_val));
         check($sformatf("u%0d s_tready", i), 64'(sr[i]), 64'(e_rdy));
         check($sformatf("u%0d grant_active", i), 64'(ga[i]), 64'(owner[i] >= 0));
         if (!rst_n) begin
            check($sformatf("u%0d tid_in_reset", i), 64'(mid[i]), 64'd0);
            check($sformatf("u%0d tdata_in_reset", i), 64'(md[i]), 64'd0);
         end
         if (e_val) begin
            check($sformatf("u%0d m_tid", i), 64'(mid[i]), 64'(owner[i]));
            check($sformatf("u%0d m_tdata", i), 64'(md[i]), 64'(e_dat));
         end
         if (mv[i] && mr[i] && lg_n[i] < LOGN) begin
            lg_tid[i][lg_n[i]] = int'(mid[i]);
            lg_dat[i][lg_n[i]] = int'(md[i]);
            lg_cyc[i][lg_n[i]] = cyc;
            lg_n[i]++;
         end
         if (rst_n) begin
            if (owner[i] < 0) begin
               bit found = 1'b0;
               for (int k = 1; k <= N; k++) begin
                  int p;
                  p = (last[i] + k) % N;
                  if (!found && sv[i][p]) begin
                     found    = 1'b1;
                     owner[i] = p;
                     cnt[i]   = 0;
                  end
               end
            end else if (!sv[i][owner[i]]) begin
               last[i]  = owner[i];
               owner[i] = -1;
            end else if (mr[i]) begin
               acc[i][owner[i]] = 1'b1;
               cnt[i]++;
               if (cnt[i] == MB_OF[i]) begin
                  last[i]  = owner[i];
                  owner[i] = -1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      refill();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (busy() && n < budget) begin
         step();
         n++;
      end
      check("drain_within_budget", 64'(busy()), 64'd0);
      step();
   endtask

   task automatic clear_log();
      for (int i = 0; i < NI; i++) lg_n[i] = 0;
   endtask

   initial begin
      int base;
      int c0;
      int k2;
      for (int i = 0; i < NI; i++) begin
         owner[i] = -1;
         cnt[i]   = 0;
         last[i]  = N - 1;
         lg_n[i]  = 0;
         mr[i]    = 1'b0;
         sv[i]    = '0;
         sd[i]    = '0;
         for (int p = 0; p < N; p++) begin
            pend[i][p]  = 1'b0;
            acc[i][p]   = 1'b0;
            left[i][p]  = 0;
            pdata[i][p] = '0;
            nextd[i][p] = DW'(p << 8);
         end
      end
      prob    = 100;
      rdy_pct = 100;

      // Reset held for two cycles: all outputs must read zero.
      step();
      step();
      rst_n = 1'b1;

      // All ports continuously valid: MAX_BURST=4 instance serves 0,1,2,3,0 in bursts of 4.
      clear_log();
      for (int i = 0; i < NI; i++) for (int p = 0; p < N; p++) left[i][p] = 20;
      refill();
      drain(400);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("rr_order beat%0d", k), 64'(lg_tid[1][k]), 64'((k / 4) % N));
         if (k > 0) begin
            check($sformatf("rr_gap beat%0d", k), 64'(lg_cyc[1][k] - lg_cyc[1][k-1]),
                  64'((k % 4 == 0) ? 2 : 1));
         end
      end

      // Port 2 alone sends 0x10..0x14.
      clear_log();
      for (int i = 0; i < NI; i++) begin
         nextd[i][2] = 16'h10;
         left[i][2]  = 5;
      end
      refill();
      drain(100);
      check("p2_count", 64'(lg_n[0]), 64'd5);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("p2_tid beat%0d", k), 64'(lg_tid[0][k]), 64'd2);
         check($sformatf("p2_data beat%0d", k), 64'(lg_dat[0][k]), 64'(16'h10 + k));
      end
      check("p2_back_to_back", 64'(lg_cyc[0][4] - lg_cyc[0][0]), 64'd4);

      // Port 1 burst with sink stalled for 10 cycles mid-burst.
      clear_log();
      base = int'(nextd[0][1]);
      for (int i = 0; i < NI; i++) left[i][1] = 8;
      refill();
      step();
      step();
      step();
      rdy_pct = 0;
      for (int i = 0; i < NI; i++) mr[i] = 1'b0;
      for (int h = 0; h < 10; h++) begin
         step();
         check($sformatf("stall_tready h%0d", h), 64'(sr[0]), 64'd0);
         check($sformatf("stall_tvalid h%0d", h), 64'(mv[0]), 64'd1);
         check($sformatf("stall_tdata h%0d", h), 64'(md[0]), 64'(pdata[0][1]));
         check($sformatf("stall_grant h%0d", h), 64'(ga[0]), 64'd1);
      end
      rdy_pct = 100;
      for (int i = 0; i < NI; i++) mr[i] = 1'b1;
      drain(100);
      check("stall_count", 64'(lg_n[0]), 64'd8);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("stall_tid beat%0d", k), 64'(lg_tid[0][k]), 64'd1);
         check($sformatf("stall_data beat%0d", k), 64'(lg_dat[0][k]), 64'(base + k));
      end

      // Port 3 served last, then ports 0 and 3 request together: 0 wins.
      clear_log();
      for (int i = 0; i < NI; i++) left[i][3] = 1;
      refill();
      drain(50);
      for (int i = 0; i < NI; i++) begin
         left[i][0] = 1;
         left[i][3] = 1;
      end
      refill();
      drain(50);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("u%0d after3_count", i), 64'(lg_n[i]), 64'd3);
         check($sformatf("u%0d after3_first", i), 64'(lg_tid[i][1]), 64'd0);
         check($sformatf("u%0d after3_second", i), 64'(lg_tid[i][2]), 64'd3);
      end

      // Asynchronous reset during beat 2 of a port-2 burst.
      clear_log();
      base = int'(nextd[0][2]);
      for (int i = 0; i < NI; i++) left[i][2] = 6;
      refill();
      step();
      step();
      step();
      #1;
      rst_n = 1'b0;
      for (int i = 0; i < NI; i++) left[i][0] = 2;
      #1;
      check("rst_async_tvalid", 64'(mv[0]), 64'd0);
      check("rst_async_tready", 64'(sr[0]), 64'd0);
      check("rst_async_grant", 64'(ga[0]), 64'd0);
      check("rst_async_tdata", 64'(md[0]), 64'd0);
      step();
      rst_n = 1'b1;
      drain(100);
      check("rst_count", 64'(lg_n[0]), 64'd8);
      check("rst_first_after", 64'(lg_tid[0][2]), 64'd0);
      k2 = 0;
      for (int k = 0; k < lg_n[0] && k < LOGN; k++) begin
         if (lg_tid[0][k] == 2) begin
            check($sformatf("rst_p2_data seq%0d", k2), 64'(lg_dat[0][k]), 64'(base + k2));
            k2++;
         end
      end
      check("rst_p2_beats", 64'(k2), 64'd6);

      // MAX_BURST=1: three beats from port 0 take six cycles with bubbles.
      clear_log();
      for (int i = 0; i < NI; i++) left[i][0] = 3;
      refill();
      c0 = cyc;
      drain(50);
      check("mb1_count", 64'(lg_n[2]), 64'd3);
      check("mb1_total_cycles", 64'(lg_cyc[2][2] - c0 + 1), 64'd6);
      check("mb1_gap1", 64'(lg_cyc[2][1] - lg_cyc[2][0]), 64'd2);
      check("mb1_gap2", 64'(lg_cyc[2][2] - lg_cyc[2][1]), 64'd2);

      // Random traffic with random backpressure.
      clear_log();
      prob    = 55;
      rdy_pct = 70;
      for (int i = 0; i < NI; i++) for (int p = 0; p < N; p++) left[i][p] = 1000;
      for (int t = 0; t < 600; t++) step();
      for (int i = 0; i < NI; i++) for (int p = 0; p < N; p++) left[i][p] = 0;
      rdy_pct = 100;
      drain(2000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
